// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encoding, default sizes
// and a helper for sizing the chunk index.
package seq_chunk_adder_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index register width; at least one bit even when there is a single chunk.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder. Also exposes the carry into the
// top bit so the caller can form signed overflow on the final chunk.
module rca_chunk
  import seq_chunk_adder_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // Ripple the carry from bit 0 upward.
  always_comb begin
    logic [CHUNK:0] c;
    // NOTE: blocking assignments here so each stage sees the carry produced by
    // the previous stage within the same evaluation of the block.
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout     = c[CHUNK];
    c_msb_in = c[CHUNK-1];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Chunk-serial adder/subtractor: one CHUNK-bit slice per cycle through a single
// shared ripple-carry adder. Subtraction is A + ~B + ~borrow. WIDTH must be a
// multiple of CHUNK.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             C_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_cout, chunk_cmsb;

  assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

  rca_chunk #(
    .CHUNK(CHUNK)
  ) u_rca (
    .a       (chunk_a),
    .b       (chunk_b),
    .cin     (carry_q),
    .s       (chunk_s),
    .cout    (chunk_cout),
    .c_msb_in(chunk_cmsb)
  );

  // Next-state logic: accept a new operation from IDLE or DONE, step one chunk per RUN cycle.
  always_comb begin
    // NOTE: every variable driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = C_in ^ sub;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = chunk_s;
        carry_d = chunk_cout;
        if (idx_q == LAST_IDX) begin
          c_out_d = chunk_cout;
          ovf_d   = chunk_cout ^ chunk_cmsb;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are cleared along with the visible state so no
      // X ever reaches the adder, even though they are reloaded before use.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign C_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: directed cases on a 64/16 instance plus random
// scoreboarded traffic on 64/1, 64/16, 64/64 and 32/8 instances.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {C_out, overflow, sum} for a w-bit operation.
  function automatic logic [65:0] model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                        input logic cin, input logic s);
    logic [63:0] mask, av, bv, res;
    logic [65:0] tmp;
    logic co, ov;
    logic signed [65:0] sa, sb, st, maxv, minv;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    av   = a_in & mask;
    bv   = b_in & mask;
    sa   = $signed({2'b00, av} << (66 - w)) >>> (66 - w);
    sb   = $signed({2'b00, bv} << (66 - w)) >>> (66 - w);
    maxv = (66'sd1 <<< (w - 1)) - 66'sd1;
    minv = -maxv - 66'sd1;
    if (!s) begin
      res = (av + bv + 64'(cin)) & mask;
      tmp = {2'b00, av} + {2'b00, bv} + 66'(cin);
      co  = tmp[w];
      st  = sa + sb + $signed({65'd0, cin});
    end else begin
      res = (av - bv - 64'(cin)) & mask;
      co  = ({2'b00, av} >= ({2'b00, bv} + 66'(cin)));
      st  = sa - sb - $signed({65'd0, cin});
    end
    ov = (st > maxv) || (st < minv);
    return {co, ov, res};
  endfunction

  // ---------------- directed instance (64/16) ----------------
  logic        rst_n, start, c_in, sub_mode;
  logic [63:0] a, b, sum;
  logic        busy, done, c_out, ovf;
  logic [65:0] dq[$];

  seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (a),
    .B       (b),
    .C_in    (c_in),
    .sub     (sub_mode),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .C_out   (c_out),
    .overflow(ovf)
  );

  task automatic issue(input logic [63:0] a_v, input logic [63:0] b_v, input logic cin_v,
                       input logic sub_v, input logic [65:0] exp_v);
    start    = 1'b1;
    a        = a_v;
    b        = b_v;
    c_in     = cin_v;
    sub_mode = sub_v;
    dq.push_back(exp_v);
  endtask

  task automatic issue_rand();
    logic [63:0] av, bv;
    logic cv, sv;
    av = {$urandom, $urandom};
    bv = {$urandom, $urandom};
    cv = 1'($urandom);
    sv = 1'($urandom);
    issue(av, bv, cv, sv, model(64, av, bv, cv, sv));
  endtask

  // Wait for done, driving junk (ignored) operands meanwhile; check latency and result.
  task automatic wait_done(input string tag, input logic hold_start);
    int cyc;
    logic [65:0] e;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        start    = hold_start ? 1'b1 : 1'($urandom);
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        c_in     = 1'($urandom);
        sub_mode = 1'($urandom);
      end
    end while (!done && cyc < 20);
    start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'd5);
    if (done && dq.size() != 0) begin
      e = dq.pop_front();
      check({tag, "_sum"}, sum, e[63:0]);
      check({tag, "_cout"}, 64'(c_out), 64'(e[65]));
      check({tag, "_ovf"}, 64'(ovf), 64'(e[64]));
      check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    end
  endtask

  // ---------------- random instances ----------------
  function automatic int cfg_w(input int g);
    return (g == 3) ? 32 : 64;
  endfunction
  function automatic int cfg_c(input int g);
    case (g)
      0: return 1;
      1: return 16;
      2: return 64;
      default: return 8;
    endcase
  endfunction
  function automatic int cfg_n(input int g);
    case (g)
      0: return 400;
      1: return 3000;
      2: return 4000;
      default: return 3000;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int W = cfg_w(g);
    localparam int C = cfg_c(g);
    localparam int N = cfg_n(g);
    logic         r_rst_n, r_start, r_cin, r_sub;
    logic [W-1:0] r_a, r_b, r_sum;
    logic         r_busy, r_done, r_cout, r_ovf;
    logic         fin = 1'b0;
    logic [65:0]  q[$];

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_rnd (
      .clk     (clk),
      .rst_n   (r_rst_n),
      .start   (r_start),
      .A       (r_a),
      .B       (r_b),
      .C_in    (r_cin),
      .sub     (r_sub),
      .busy    (r_busy),
      .done    (r_done),
      .sum     (r_sum),
      .C_out   (r_cout),
      .overflow(r_ovf)
    );

    // Drive random operations (and ignored junk while busy); pop and compare on every done.
    initial begin
      int issued, guard;
      logic [65:0] e;
      r_rst_n = 1'b0;
      r_start = 1'b0;
      r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
      issued = 0;
      guard  = 0;
      repeat (3) @(negedge clk);
      r_rst_n = 1'b1;
      while (guard < 90000 && (issued < N || q.size() != 0)) begin
        @(negedge clk);
        guard++;
        if (r_done) begin
          if (q.size() == 0) begin
            check($sformatf("rnd%0d_spurious_done", g), 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check($sformatf("rnd%0d_sum", g), 64'(r_sum), e[63:0]);
            check($sformatf("rnd%0d_cout", g), 64'(r_cout), 64'(e[65]));
            check($sformatf("rnd%0d_ovf", g), 64'(r_ovf), 64'(e[64]));
            check($sformatf("rnd%0d_busy_in_done", g), 64'(r_busy), 64'd0);
          end
        end
        if (!r_busy && issued < N && $urandom_range(3) != 0) begin
          r_a   = ($urandom_range(7) == 0) ? '1 : W'({$urandom, $urandom});
          r_b   = ($urandom_range(7) == 0) ? '0 : W'({$urandom, $urandom});
          r_cin = 1'($urandom);
          r_sub = 1'($urandom);
          r_start = 1'b1;
          q.push_back(model(W, 64'(r_a), 64'(r_b), r_cin, r_sub));
          issued++;
        end else if (r_busy) begin
          r_start = 1'($urandom);
          r_a     = W'({$urandom, $urandom});
          r_b     = W'({$urandom, $urandom});
          r_cin   = 1'($urandom);
          r_sub   = 1'($urandom);
        end else begin
          r_start = 1'b0;
        end
      end
      r_start = 1'b0;
      check($sformatf("rnd%0d_issued", g), 64'(issued), 64'(N));
      check($sformatf("rnd%0d_drained", g), 64'(q.size()), 64'd0);
      fin = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int seen, guard;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", 64'(c_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, {1'b1, 1'b0, 64'h1});
    wait_done("add_wrap", 1'b0);
    @(negedge clk);
    check("hold_idle_sum", sum, 64'h1);
    check("hold_idle_cout", 64'(c_out), 64'd1);
    check("idle_done_low", 64'(done), 64'd0);

    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b0, 1'b1, 64'h8000_0000_0000_0000});
    wait_done("add_ovf", 1'b0);
    @(negedge clk);

    issue(64'd5, 64'd7, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    wait_done("sub_borrow", 1'b0);

    // Back-to-back: start held high, new operands presented in each DONE cycle.
    for (int k = 0; k < 4; k++) begin
      issue_rand();
      wait_done($sformatf("b2b%0d", k), 1'b1);
    end
    @(negedge clk);

    issue(64'd3, 64'd4, 1'b0, 1'b0, {1'b0, 1'b0, 64'd7});
    wait_done("pre_rst", 1'b0);
    @(negedge clk);

    // Abort during chunk 2 of an operation.
    issue_rand();
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    dq.delete();
    check("abort_sum", sum, 64'd0);
    check("abort_cout", 64'(c_out), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    issue_rand();
    wait_done("post_rst", 1'b0);

    guard = 0;
    while (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin && g_rnd[3].fin) && guard < 95000) begin
      @(negedge clk);
      guard++;
    end
    check("rnd_all_finished",
          64'({g_rnd[3].fin, g_rnd[2].fin, g_rnd[1].fin, g_rnd[0].fin}), 64'hF);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, bits added per cycle; WIDTH % CHUNK == 0 required, NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port A  input  WIDTH  operand A, sampled on accepted start.
REQ-007 SHALL have port B  input  WIDTH  operand B, sampled on accepted start.
REQ-008 SHALL have port C_in  input  1  carry-in (add) / borrow-in (sub), sampled on accepted start.
REQ-009 SHALL have port sub  input  1  mode, 0 = A+B+C_in, 1 = A-B-C_in; sampled on accepted start.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port C_out  output  1  raw carry out of bit WIDTH-1.
REQ-014 SHALL have port overflow  output  1  two's-complement signed overflow of the result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: start=1 SHALL latch A, B (inverted when sub=1), and carry = C_in XOR sub; clear chunk index to 0; go to RUN.
REQ-017 RUN: each cycle SHALL add chunk[idx] of latched A and B with the running carry, write sum chunk idx, and register the chunk carry-out.
REQ-018 RUN SHALL go to DONE after chunk NCHUNK-1; idx SHALL count 0..NCHUNK-1 with no wrap beyond.
REQ-019 DONE: done=1 for exactly one cycle; sum/C_out/overflow valid; then go to IDLE unless start=1.
REQ-020 start=1 in DONE SHALL be accepted as in IDLE, giving back-to-back operations with no idle cycle.
REQ-021 start while in RUN SHALL be ignored; latched operands SHALL not change.
REQ-022 Latency: done SHALL assert exactly NCHUNK+1 cycles after the cycle start is accepted (NCHUNK cycles in RUN).
REQ-023 busy SHALL be 1 in RUN, 0 in IDLE and DONE.
REQ-024 sum, C_out, overflow SHALL hold their last valid values in IDLE and DONE until the next result's final chunk is written; sum is undefined-but-stable in RUN.
REQ-025 overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-026 CHUNK == WIDTH SHALL be legal: one RUN cycle.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, C_out=0, overflow=0, idx=0, carry=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-029 First accepted start SHALL be the first rising edge of clk with rst_n high and start=1.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding (IDLE/RUN/DONE) and default WIDTH/CHUNK constants.
REQ-031 One sub-module rca_chunk SHALL implement a combinational CHUNK-bit ripple-carry adder (a, b, cin -> s, cout, c_msb_in), instantiated once and reused each RUN cycle.

Verification
REQ-032 A=64'hFFFFFFFFFFFFFFFF, B=1, C_in=1, sub=0 -> done 5 cycles after start, sum=64'h1, C_out=1, overflow=0.
REQ-033 A=64'h7FFFFFFFFFFFFFFF, B=1, C_in=0, sub=0 -> sum=64'h8000000000000000, C_out=0, overflow=1.
REQ-034 A=5, B=7, C_in=0, sub=1 -> sum=64'hFFFFFFFFFFFFFFFE, C_out=0 (borrow), overflow=0.
REQ-035 start held high continuously with new operands each DONE -> one done pulse every 5 cycles, each result correct, busy never high in DONE.
REQ-036 rst_n pulsed low during RUN chunk 2 -> outputs 0 immediately, no done pulse; next start completes normally.
REQ-037 Random 10k operations both modes, WIDTH=64/CHUNK in {1,16,64}, WIDTH=32/CHUNK=8 -> match behavioural model on every done.
